// File: rtl/n8_poll_scheduler.sv
// Shared-bus poll scheduler for two NES-style 8-button pads: drives the common
// latch/shift-clock pair from a tick divider and commits active-high button bytes.
module n8_poll_scheduler #(
  parameter int CLK_DIV    = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       poll_now,
  input  logic [1:0] data_in,
  output logic       ltch,
  output logic       pulse,
  output logic [7:0] pad0_btn,
  output logic [7:0] pad1_btn,
  output logic       btn_valid,
  output logic       btn_changed,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = $clog2(POLL_TICKS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_TICKS - 1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  logic [DIV_W-1:0] div_r;
  logic [PER_W-1:0] period_r;
  logic             pending_r;
  logic             tick_s;
  logic             start_s;

  state_t     state_r, state_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic       latch_half_r, latch_half_s;
  logic [7:0] sh0_r, sh0_s;
  logic [7:0] sh1_r, sh1_s;
  logic [7:0] pad0_r, pad0_s;
  logic [7:0] pad1_r, pad1_s;
  logic       valid_r, valid_s;
  logic       changed_r, changed_s;
  logic       ltch_r, ltch_s;
  logic       pulse_r, pulse_s;
  logic       busy_r, busy_s;

  assign tick_s = (div_r == DIV_LAST);

  // Free-running tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Poll period counter, parked at zero while polling is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r <= {PER_W{1'b0}};
    end else if (!enable) begin
      period_r <= {PER_W{1'b0}};
    end else if (tick_s) begin
      period_r <= (period_r == PER_LAST) ? {PER_W{1'b0}} : period_r + PER_ONE;
    end else begin
      period_r <= period_r;
    end
  end

  // Single-entry queue for poll_now; a starting poll consumes it, even one arriving that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (start_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r | poll_now;
    end
  end

  // Next-state, sampling and commit logic; pin outputs follow the next state.
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    latch_half_s = latch_half_r;
    sh0_s        = sh0_r;
    sh1_s        = sh1_r;
    pad0_s       = pad0_r;
    pad1_s       = pad1_r;
    valid_s      = 1'b0;
    changed_s    = 1'b0;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && ((enable && (period_r == {PER_W{1'b0}})) || pending_r)) begin
          start_s      = 1'b1;
          state_s      = ST_LATCH;
          latch_half_s = 1'b0;
          bit_idx_s    = 3'd0;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_LATCH: begin
        if (tick_s && latch_half_r) begin
          sh0_s        = {data_in[0], sh0_r[7:1]};
          sh1_s        = {data_in[1], sh1_r[7:1]};
          latch_half_s = 1'b0;
          bit_idx_s    = 3'd1;
          state_s      = ST_SHIFT_LO;
        end else if (tick_s) begin
          latch_half_s = 1'b1;
        end else begin
          latch_half_s = latch_half_r;
        end
      end
      ST_SHIFT_LO: begin
        if (tick_s) begin
          state_s = ST_SHIFT_HI;
        end else begin
          state_s = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (tick_s) begin
          sh0_s = {data_in[0], sh0_r[7:1]};
          sh1_s = {data_in[1], sh1_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = ST_COMMIT;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            state_s   = ST_SHIFT_LO;
          end
        end else begin
          state_s = ST_SHIFT_HI;
        end
      end
      ST_COMMIT: begin
        pad0_s    = ~sh0_r;
        pad1_s    = ~sh1_r;
        valid_s   = 1'b1;
        changed_s = (~sh0_r != pad0_r) || (~sh1_r != pad1_r);
        bit_idx_s = 3'd0;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ltch_s  = (state_s == ST_LATCH);
    pulse_s = (state_s == ST_SHIFT_HI);
    busy_s  = (state_s != ST_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_idx_r    <= 3'd0;
      latch_half_r <= 1'b0;
      sh0_r        <= 8'h00;
      sh1_r        <= 8'h00;
      pad0_r       <= 8'h00;
      pad1_r       <= 8'h00;
      valid_r      <= 1'b0;
      changed_r    <= 1'b0;
      ltch_r       <= 1'b0;
      pulse_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_idx_r    <= bit_idx_s;
      latch_half_r <= latch_half_s;
      sh0_r        <= sh0_s;
      sh1_r        <= sh1_s;
      pad0_r       <= pad0_s;
      pad1_r       <= pad1_s;
      valid_r      <= valid_s;
      changed_r    <= changed_s;
      ltch_r       <= ltch_s;
      pulse_r      <= pulse_s;
      busy_r       <= busy_s;
    end
  end

  assign ltch        = ltch_r;
  assign pulse       = pulse_r;
  assign pad0_btn    = pad0_r;
  assign pad1_btn    = pad1_r;
  assign btn_valid   = valid_r;
  assign btn_changed = changed_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_n8_poll_scheduler.sv
// Randomized bench for n8_poll_scheduler: pad model plus a tick/period/pending
// reference model predicting poll starts, commits and committed bytes.
module tb_n8_poll_scheduler;

  localparam int CLK_DIV    = 4;
  localparam int POLL_TICKS = 20;
  localparam int POLL_CLKS  = 16 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       poll_now = 1'b0;
  logic [1:0] data_in;
  logic       ltch, pulse, btn_valid, btn_changed, busy;
  logic [7:0] pad0_btn, pad1_btn;

  n8_poll_scheduler #(.CLK_DIV(CLK_DIV), .POLL_TICKS(POLL_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .poll_now(poll_now), .data_in(data_in),
    .ltch(ltch), .pulse(pulse), .pad0_btn(pad0_btn), .pad1_btn(pad1_btn),
    .btn_valid(btn_valid), .btn_changed(btn_changed), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pad model: pressed keys (active-high); latch reloads, each pulse rise shifts.
  logic [7:0] keys0 = 8'h00;
  logic [7:0] keys1 = 8'h00;
  int pad_idx = 0;
  initial forever begin
    @(posedge ltch or posedge pulse);
    if (ltch) pad_idx = 0;
    else pad_idx = pad_idx + 1;
  end
  assign data_in = (pad_idx < 8) ? {~keys1[pad_idx[2:0]], ~keys0[pad_idx[2:0]]} : 2'b11;

  // Reference model: clk edges since reset, ticks every CLK_DIV-th edge.
  int         m_edge, m_per, m_commit_at;
  bit         m_pend, m_busy, m_started, m_commit_ev, m_tick, m_start;
  logic [7:0] m_k0, m_k1, m_prev0, m_prev1, m_shown0, m_shown1;
  bit         m_exp_chg;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_edge = 0; m_per = 0; m_pend = 0; m_busy = 0; m_started = 0; m_commit_ev = 0;
      m_commit_at = -1; m_prev0 = 8'h00; m_prev1 = 8'h00; m_shown0 = 8'h00; m_shown1 = 8'h00;
      m_exp_chg = 0;
    end else begin
      m_edge++;
      m_tick = (m_edge % CLK_DIV) == 0;
      m_started = 0;
      m_commit_ev = 0;
      if (m_busy && m_edge == m_commit_at) begin
        m_commit_ev = 1;
        m_busy = 0;
        m_shown0 = m_k0;
        m_shown1 = m_k1;
      end
      m_start = m_tick && !m_busy && ((enable && m_per == 0) || m_pend);
      m_pend = m_start ? 1'b0 : (m_pend | poll_now);
      if (!enable) m_per = 0;
      else if (m_tick) m_per = (m_per + 1) % POLL_TICKS;
      if (m_start) begin
        m_started = 1;
        m_busy = 1;
        m_commit_at = m_edge + POLL_CLKS;
        m_k0 = keys0;
        m_k1 = keys1;
        m_exp_chg = (keys0 != m_prev0) || (keys1 != m_prev1);
        m_prev0 = keys0;
        m_prev1 = keys1;
      end
    end
  end

  // Output checker, sampled on the falling edge.
  bit ltch_q = 0, pulse_q = 0, rise;
  int ltch_cyc = 0, pulse_cyc = 0, pulse_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ltch_q = 0;
      pulse_q = 0;
    end else begin
      rise = ltch && !ltch_q;
      if (rise) begin
        ltch_cyc = 0; pulse_cyc = 0; pulse_cnt = 0;
      end
      if (ltch) ltch_cyc++;
      if (pulse) pulse_cyc++;
      if (pulse && !pulse_q) pulse_cnt++;
      ltch_q = ltch;
      pulse_q = pulse;
      if (rise || m_started) check_eq("poll_start", rise, m_started);
      check_eq("busy", busy, m_busy);
      check_eq("pad0_hold", pad0_btn, m_shown0);
      check_eq("pad1_hold", pad1_btn, m_shown1);
      if (btn_valid || m_commit_ev) begin
        check_eq("btn_valid", btn_valid, m_commit_ev);
        if (m_commit_ev) begin
          check_eq("btn_changed", btn_changed, m_exp_chg);
          check_eq("ltch_width", ltch_cyc, 2 * CLK_DIV);
          check_eq("pulse_count", pulse_cnt, 7);
          check_eq("pulse_high_clks", pulse_cyc, 7 * CLK_DIV);
        end
      end else begin
        check_eq("changed_idle", btn_changed, 1'b0);
      end
    end
  end

  task automatic step(input bit rnd);
    @(negedge clk);
    poll_now = 1'b0;
    if (rnd) begin
      if (!busy && $urandom_range(7, 0) == 0) begin
        keys0 = 8'($urandom);
        keys1 = 8'($urandom);
      end
      if ($urandom_range(29, 0) == 0) poll_now = 1'b1;
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) step(rnd);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step(1'b0);
      n++;
    end
    check_eq("idle_timeout", busy, 1'b0);
  endtask

  task automatic pulse_poll_now();
    poll_now = 1'b1;
    step(1'b0);
  endtask

  initial begin
    int n;
    int cnt;
    bit pq;
    run(3, 1'b0);
    check_eq("rst_ltch", ltch, 1'b0);
    check_eq("rst_pulse", pulse, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", btn_valid, 1'b0);
    check_eq("rst_pads", {pad1_btn, pad0_btn}, 16'h0000);
    rst_n = 1'b1;
    enable = 1'b1;
    run(180, 1'b0);

    wait_idle();
    keys0 = 8'h81;
    keys1 = 8'h01;
    run(170, 1'b0);
    check_eq("pad0_a_right", pad0_btn, 8'h81);
    check_eq("pad1_a", pad1_btn, 8'h01);

    enable = 1'b0;
    wait_idle();
    run(10, 1'b0);
    pulse_poll_now();
    run(300, 1'b0);

    pulse_poll_now();
    n = 0;
    while (!busy && n < 20) begin step(1'b0); n++; end
    check_eq("busy_timeout", busy, 1'b1);
    run(10, 1'b0);
    pulse_poll_now();
    run(20, 1'b0);
    pulse_poll_now();
    run(300, 1'b0);

    wait_idle();
    enable = 1'b1;
    cnt = 0; pq = 0; n = 0;
    while (cnt < 3 && n < 400) begin
      step(1'b0);
      if (pulse && !pq) cnt++;
      pq = pulse;
      n++;
    end
    check_eq("pulse3_timeout", cnt, 3);
    enable = 1'b0;
    run(250, 1'b0);

    for (int it = 0; it < 40; it++) begin
      enable = ($urandom_range(3, 0) != 0);
      run($urandom_range(120, 10), 1'b1);
    end

    enable = 1'b1;
    wait_idle();
    keys0 = 8'h5A;
    keys1 = 8'hC3;
    run(200, 1'b0);
    n = 0;
    while (!pulse && n < 200) begin step(1'b0); n++; end
    check_eq("pulse_timeout", pulse, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ltch", ltch, 1'b0);
    check_eq("arst_pulse", pulse, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_pads", {pad1_btn, pad0_btn}, 16'h0000);
    run(2, 1'b0);
    rst_n = 1'b1;
    run(150, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n8_poll_scheduler.md
Name: n8_poll_scheduler

Overview:
- Sequences periodic reads of two NES-style 8-button pads. The pads share one latch line and one clock (pulse) line; each pad has its own serial data line.
- Generates the `ltch`/`pulse` waveform from a programmable tick and samples both data lines.
- Commits de-serialised, active-high button bytes together with a valid strobe and a change flag.
- Sits between the pad connector pins and game/LED logic. It is the shared-bus scheduler for the controller port.

Parameters:
- CLK_DIV, 300, clk cycles per timing tick (6 us at 50 MHz); min 2
- POLL_TICKS, 2778, ticks between poll starts (~60 Hz); min 17

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = periodic polling allowed
- poll_now  in  1  single-cycle request for an immediate extra poll
- data_in  in  2  serial data, [0]=pad0, [1]=pad1, active-low (0 = pressed)
- ltch  out  1  shared latch to pads
- pulse  out  1  shared shift clock to pads
- pad0_btn  out  8  pad0 buttons, active-high
- pad1_btn  out  8  pad1 buttons, active-high
- btn_valid  out  1  1-clk strobe when new bytes are committed
- btn_changed  out  1  1-clk strobe, asserted with btn_valid if either byte differs from the previous commit
- busy  out  1  1 while a poll sequence is in progress

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; FSM to IDLE
  - tick divider, period counter, bit index and pending flag all 0
  - takes effect immediately, including mid-poll; the partial sample is discarded.
- Tick generation:
  - divider counts 0..CLK_DIV-1; `tick`=1 for the one clk where divider==CLK_DIV-1
  - divider free-runs regardless of state.
- Period counter:
  - advances on tick while enable=1, wrapping at POLL_TICKS-1
  - forced to 0 while enable=0.
- Poll start condition, evaluated on a tick while in IDLE:
  - (enable=1 and period counter==0) or pending=1
  - consequence: the first poll after reset/enable rise starts on the first tick.
- poll_now handling:
  - sets pending on any clk
  - pending clears when a poll starts
  - only one request is queued; extra requests while pending=1 are absorbed.
- All outputs are registered. ltch/pulse change only on the clk following a tick.
- FSM:
  - IDLE: ltch=0, pulse=0, busy=0. On start condition -> LATCH; busy=1.
  - LATCH: ltch=1 for 2 ticks. At the end of the 2nd tick, sample bit0 of both pads, then ltch=0 -> SHIFT_LO with k=1.
  - SHIFT_LO: pulse=0 for 1 tick -> SHIFT_HI.
  - SHIFT_HI: pulse=1 for 1 tick. At its end, sample bit k of both pads. If k==7 -> COMMIT, else k=k+1 -> SHIFT_LO.
  - COMMIT: exactly 1 clk (not a tick). Then -> IDLE; busy=0.
    - pad*_btn <= ~shift registers
    - btn_valid=1
    - btn_changed=1 if either new byte != old byte
- Sequence totals: 2 latch ticks + 7 pulses = 16 ticks per poll; pulse is high 7 times.
- Bit mapping (serial order): btn[0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- pad*_btn hold their value between commits.
- Boundary conditions:
  - enable dropping mid-poll: the current poll completes and commits; no new periodic start.
  - poll_now arriving in the same clk as a periodic start: one poll runs; pending is cleared.
  - poll_now arriving during busy: the poll runs on the first tick after COMMIT.
  - First commit after reset compares against the 0 reset value, so btn_changed=1 if any button is pressed.

Test Plan (CLK_DIV=4, POLL_TICKS=20):
- Reset release, enable=1, both data_in held 1 -> ltch high for 8 clks starting ~4 clks after release; 7 pulses of 4 clks high/4 low; btn_valid strobe; pad0_btn=pad1_btn=8'h00; btn_changed=0; next ltch rise 80 clks after the first.
- Bench pad model shifting 8'b0111_1110 on pad0 and 8'b1111_1110 on pad1 (A first, active-low) -> pad0_btn=8'h81 (A, Right); pad1_btn=8'h01 (A); btn_changed=1; then same stimulus again -> btn_changed=0.
- enable=0, poll_now pulse at an idle clk -> exactly one poll and one btn_valid; no further ltch for 200 clks.
- poll_now twice during busy with enable=0 -> exactly one extra poll, whose ltch rises on the first tick after COMMIT.
- enable falls at pulse #3 -> poll finishes (7 pulses) and commits; no subsequent poll.
- rst_n low mid-SHIFT_HI -> ltch, pulse, busy and pad*_btn are 0 in the same cycle; after release, a clean poll starts on the first tick.
